gpio_serial_loader: RTL
=======================

GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

Interface
REQ-001 SHALL have parameter CLKDIV, default 1: sys cycles per serial_clock half-period, legal 1..255.
REQ-002 SHALL have parameter CFG_W, default 13: config bits per GPIO block.
REQ-003 SHALL have ports:
- wb_clk_i  in  1  sole clock.
- wb_rstn_i  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle load request.
- gpio_defaults  in  38*CFG_W  parallel defaults; GPIO n at [CFG_W*n +: CFG_W].
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- serial_clock  out  1  chain shift clock.
- serial_load  out  1  chain latch strobe.
- serial_resetn  out  1  chain reset, active-low.
- serial_data_1  out  1  chain 1 data (GPIO 0..18).
- serial_data_2  out  1  chain 2 data (GPIO 37..19).

Function
REQ-004 SHALL use states IDLE, CRST, SHIFT, LOAD, FIN; a state change SHALL occur only at a half-period tick, except IDLE->CRST.
REQ-005 SHALL, in IDLE, drive busy=0, serial_resetn=1, serial_clock=0, serial_load=0, serial_data_1=serial_data_2=0.
REQ-006 SHALL, on start=1 in IDLE, capture gpio_defaults into a shadow register the same edge, enter CRST, and assert busy the next cycle.
REQ-007 SHALL ignore start while busy=1; the shadow SHALL NOT change mid-transfer.
REQ-008 SHALL, in CRST, hold serial_resetn=0 for 2*CLKDIV cycles, then enter SHIFT.
REQ-009 SHALL shift exactly 247 (19*CFG_W) bits per chain, both chains in lockstep.
REQ-010 SHALL present each bit with serial_clock low for CLKDIV cycles, then hold serial_clock high for CLKDIV cycles; data SHALL change only on the falling edge.
REQ-011 SHALL order chain 1 as GPIO 18 first, down to GPIO 0 last; chain 2 as GPIO 19 first, up to GPIO 37 last. Within each GPIO, bits go MSB (bit 12) first.
REQ-012 SHALL use an 8-bit bit counter. After the 247th falling edge it SHALL enter LOAD with serial_clock=0, with no wrap and no extra clock edge.
REQ-013 SHALL, in LOAD, hold serial_load=1 for CLKDIV cycles, then enter FIN.
REQ-014 SHALL, in FIN, hold serial_load=0 for CLKDIV cycles, then on the exit edge drive done=1 and busy=0 for one cycle and return to IDLE.
REQ-015 SHALL give a total busy duration of (2 + 494 + 2)*CLKDIV cycles, i.e. 498 cycles at CLKDIV=1.
REQ-016 SHALL, when start arrives in the same cycle done pulses, ignore it; the next start is accepted from IDLE only.

Reset
REQ-017 SHALL, on wb_rstn_i=0, immediately force the following, regardless of state:
- state=IDLE, counters=0, shadow=0.
- busy=0, done=0, serial_clock=0, serial_load=0, serial_data_1=serial_data_2=0.
- serial_resetn=0.
REQ-018 SHALL drive serial_resetn=1 from the first wb_clk_i edge after reset release.
REQ-019 SHALL, when reset is asserted mid-SHIFT, emit no serial_load pulse; chain contents are discarded.

Structure
REQ-020 SHALL take CFG_W=13, NCHAIN_GPIO=19, NGPIO=38, SHIFT_BITS=247 and the state enum from shared package gpio_loader_pkg.
REQ-021 SHALL place the CLKDIV half-period tick generator in sub-module gpio_serial_clkgen (inputs: clk, rstn, enable; output: one-cycle tick). The counter SHALL restart on enable rise.

Verification
REQ-022 Bench SHALL cover these scenarios:
- Reset, CLKDIV=1: start pulse -> busy=1 for exactly 498 cycles, 247 serial_clock rises, one serial_load pulse 1 cycle wide, done 1 cycle.
- GPIO0=13'h1803, GPIO37=13'h0403, others 0: the last 13 bits on serial_data_1 are 1100000000011 and the last 13 on serial_data_2 are 0010000000011, each sampled on serial_clock rise; both chains are 0 elsewhere.
- Model: 38 chained 13-bit shift registers, clocked by serial_clock and latched on serial_load -> latched contents equal gpio_defaults for random values (10 seeds).
- CLKDIV=4: every serial_clock high/low phase is exactly 4 cycles; busy lasts 1992 cycles.
- Second start pulse in SHIFT, plus gpio_defaults changed mid-transfer -> no restart; the shifted data equals the values captured at the first start.
- wb_rstn_i pulsed low at bit 100 -> all outputs at reset values within the same cycle, no serial_load pulse, serial_resetn=1 one cycle after release; a fresh start then completes normally.

Source files
------------

// File: rtl/gpio_loader_pkg.sv
// Shared constants and state encoding for the GPIO serial configuration loader.
package gpio_loader_pkg;

  localparam int CFG_W       = 13;                  // config bits per GPIO block
  localparam int NCHAIN_GPIO = 19;                  // GPIO blocks on each chain
  localparam int NGPIO       = 38;                  // total GPIO blocks
  localparam int SHIFT_BITS  = NCHAIN_GPIO * CFG_W; // bits shifted per chain (247)
  localparam int BIT_CNT_W   = 8;                   // width of the per-chain bit counter

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CRST  = 3'd1,
    SHIFT = 3'd2,
    LOAD  = 3'd3,
    FIN   = 3'd4
  } loader_state_e;

endpackage

// File: rtl/gpio_serial_clkgen.sv
// Half-period tick generator: pulses tick for one cycle every CLKDIV cycles
// while enabled. The counter is held at zero while disabled, so the count
// restarts cleanly each time enable rises.
module gpio_serial_clkgen #(
  parameter int CLKDIV = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  output logic tick
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = enable && (cnt_q == 8'(CLKDIV - 1));

  // Next count: clear when idle or on a tick, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Serialises 38 GPIO configuration words onto two daisy chains, then strobes
// serial_load so the chains latch the shifted values. Chain 1 carries GPIO
// 18 down to 0, chain 2 carries GPIO 19 up to 37, each word MSB first.
module gpio_serial_loader #(
  parameter int CLKDIV = 1,
  parameter int CFG_W  = gpio_loader_pkg::CFG_W
) (
  input  logic                                     wb_clk_i,
  input  logic                                     wb_rstn_i,
  input  logic                                     start,
  input  logic [gpio_loader_pkg::NGPIO*CFG_W-1:0]  gpio_defaults,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     serial_clock,
  output logic                                     serial_load,
  output logic                                     serial_resetn,
  output logic                                     serial_data_1,
  output logic                                     serial_data_2
);

  import gpio_loader_pkg::*;

  localparam int DW    = NGPIO * CFG_W;
  localparam int NBITS = NCHAIN_GPIO * CFG_W;  // equals SHIFT_BITS at the default width
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NBITS - 1);

  loader_state_e          state_q, state_d;
  logic                   half_cnt_q, half_cnt_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   sclk_q, sclk_d;
  logic                   done_q, done_d;
  logic                   resetn_q, resetn_d;
  logic [DW-1:0]          shadow_q, shadow_d;
  logic                   tick;
  logic [NBITS-1:0]       chain1_vec;
  logic [NBITS-1:0]       chain2_vec;
  logic [BIT_CNT_W-1:0]   bit_idx;

  gpio_serial_clkgen #(
    .CLKDIV (CLKDIV)
  ) u_clkgen (
    .clk    (wb_clk_i),
    .rstn   (wb_rstn_i),
    .enable (state_q != IDLE),
    .tick   (tick)
  );

  // Chain 1 order (GPIO 18 MSB first ... GPIO 0 LSB last) is exactly the
  // lower half of the shadow read from the top down.
  assign chain1_vec = shadow_q[NBITS-1:0];

  // Chain 2 reverses the word order of the upper half so GPIO 19 sits on top.
  for (genvar gi = 0; gi < NCHAIN_GPIO; gi++) begin : g_chain2
    assign chain2_vec[CFG_W*(NCHAIN_GPIO-1-gi) +: CFG_W] =
        shadow_q[CFG_W*(NCHAIN_GPIO+gi) +: CFG_W];
  end

  assign bit_idx       = LAST_BIT - bit_cnt_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = (state_q == LOAD);
  assign serial_resetn = resetn_q && (state_q != CRST);
  assign serial_data_1 = (state_q == SHIFT) ? chain1_vec[bit_idx] : 1'b0;
  assign serial_data_2 = (state_q == SHIFT) ? chain2_vec[bit_idx] : 1'b0;

  // Sequencer: every transition except IDLE->CRST waits for a half-period tick.
  always_comb begin
    state_d    = state_q;
    half_cnt_d = half_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    done_d     = 1'b0;
    shadow_d   = shadow_q;
    resetn_d   = 1'b1;
    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          state_d  = CRST;
          shadow_d = gpio_defaults;
        end
      end
      CRST: begin
        if (tick) begin
          if (half_cnt_q) begin
            state_d    = SHIFT;
            half_cnt_d = 1'b0;
          end else begin
            half_cnt_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: advance to the next bit, or finish after the last.
            sclk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d   = LOAD;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      LOAD: begin
        if (tick) state_d = FIN;
      end
      FIN: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including the shadow.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q    <= IDLE;
      half_cnt_q <= 1'b0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      done_q     <= 1'b0;
      resetn_q   <= 1'b0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      half_cnt_q <= half_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sclk_q     <= sclk_d;
      done_q     <= done_d;
      resetn_q   <= resetn_d;
      shadow_q   <= shadow_d;
    end
  end

endmodule
